// File: rtl/accel_dma_pkg.sv
// accel_dma_pkg: register offsets, CTRL/STATUS bit positions, FSM encoding and byte-strobe helper shared by accel_result_dma
package accel_dma_pkg;
  localparam logic [3:0] CTRL_OFS = 4'h0;
  localparam logic [3:0] BASE_OFS = 4'h4;
  localparam logic [3:0] LEN_OFS = 4'h8;
  localparam logic [3:0] STATUS_OFS = 4'hC;
  localparam int CTRL_START = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT = 2;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR = 2;
  localparam int ST_ABORTED = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, WRITE = 2'd2, DONE_ST = 2'd3} state_t;
  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
endpackage

// File: rtl/accel_result_dma.sv
// accel_result_dma: drains the accelerator output FIFO into memory; ports clk/rst, fifo_rdata/fifo_empty/fifo_pop, mem_* write master, cfg_* CPU register slave, irq
module accel_result_dma
  import accel_dma_pkg::*;
#(
  parameter int MAX_LEN = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fifo_rdata,
  input  logic        fifo_empty,
  output logic        fifo_pop,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        cfg_sel,
  input  logic [3:0]  cfg_addr,
  input  logic [3:0]  cfg_wstrb,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        cfg_ready,
  output logic        irq
);
  localparam logic [31:0] MAX_W = 32'(MAX_LEN);
  state_t state, state_d;
  logic sel_d, irq_en, done, err, aborted;
  logic [31:0] base, len, addr, remain, data, mask, base_w, len_w, rd;
  logic [15:0] count;
  logic wr, ctrl_wr, start, abort, w1c, busy, go, bad_base;
  assign mask = byte_mask(cfg_wstrb);
  assign base_w = (base & ~mask) | (cfg_wdata & mask);
  assign len_w = (len & ~mask) | (cfg_wdata & mask);
  assign wr = cfg_ready && cfg_wstrb != 4'h0;
  assign ctrl_wr = wr && cfg_addr == CTRL_OFS && cfg_wstrb[0];
  assign start = ctrl_wr && cfg_wdata[CTRL_START];
  assign abort = ctrl_wr && cfg_wdata[CTRL_ABORT];
  assign w1c = wr && cfg_addr == STATUS_OFS && cfg_wstrb[0] && cfg_wdata[ST_DONE];
  assign busy = state == FETCH || state == WRITE;
  assign go = state == IDLE && start;
  assign bad_base = base[1:0] != 2'b00;
  assign fifo_pop = state == FETCH && !fifo_empty && !abort;
  assign mem_valid = state == WRITE;
  assign mem_wstrb = mem_valid ? 4'hF : 4'h0;
  assign mem_addr = addr;
  assign mem_wdata = data;
  assign irq = done && irq_en;
  assign rd = cfg_addr == CTRL_OFS ? 32'(irq_en) << CTRL_IRQ_EN :
              cfg_addr == BASE_OFS ? base :
              cfg_addr == LEN_OFS ? len :
              cfg_addr == STATUS_OFS ? {count, 12'd0, aborted, err, done, busy} : 32'd0;
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = go && !bad_base ? (len == 32'd0 ? DONE_ST : FETCH) : IDLE;
      FETCH: state_d = abort ? DONE_ST : fifo_empty ? FETCH : WRITE;
      WRITE: state_d = !mem_ready ? WRITE : (remain == 32'd1 || aborted || abort) ? DONE_ST : FETCH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk)
    if (rst) begin
      sel_d <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_rdata <= 32'd0;
      irq_en <= 1'b0;
      base <= 32'd0;
      len <= 32'd0;
    end else begin
      sel_d <= cfg_sel;
      cfg_ready <= cfg_sel && !sel_d;
      if (cfg_sel && !sel_d) cfg_rdata <= rd;
      if (ctrl_wr) irq_en <= cfg_wdata[CTRL_IRQ_EN];
      if (wr && cfg_addr == BASE_OFS) base <= base_w;
      if (wr && cfg_addr == LEN_OFS) len <= len_w > MAX_W ? MAX_W : len_w;
    end
  always_ff @(posedge clk)
    if (rst) begin
      done <= 1'b0;
      err <= 1'b0;
      aborted <= 1'b0;
      count <= 16'd0;
      addr <= 32'd0;
      remain <= 32'd0;
      data <= 32'd0;
    end else begin
      done <= (state == DONE_ST || (go && bad_base)) ? 1'b1 : (go || w1c) ? 1'b0 : done;
      if (go) begin
        err <= bad_base;
        aborted <= 1'b0;
        count <= 16'd0;
        addr <= base;
        remain <= len;
      end
      if (busy && abort) aborted <= 1'b1;
      if (fifo_pop) data <= fifo_rdata;
      if (mem_valid && mem_ready) begin
        addr <= addr + 32'd4;
        count <= count + 16'd1;
        remain <= remain - 32'd1;
      end
    end
endmodule

// File: tb/tb_accel_result_dma.sv
// tb_accel_result_dma: randomized self-checking bench with a FIFO/memory responder and a transfer-level reference model
module tb_accel_result_dma;
  import accel_dma_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] fifo_rdata, mem_addr, mem_wdata, cfg_wdata, cfg_rdata;
  logic fifo_empty, fifo_pop, mem_valid, mem_ready, cfg_sel, cfg_ready, irq;
  logic [3:0] mem_wstrb, cfg_addr, cfg_wstrb;
  int checks = 0, errors = 0;
  logic [31:0] fq[$];
  logic [31:0] ga[$];
  logic [31:0] gd[$];
  int gc[$];
  int cyc = 0, pops = 0, bad_pop = 0, unstable = 0, bad_strb = 0;
  int rdy_delay = 0, wait_cnt = 0, rdy_cyc = 0;
  bit rdy_hold = 0, blk_force = 0, gap_mode = 0, gap_blk = 0, pop_seen = 0;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [31:0] prev_a = 32'd0, prev_d = 32'd0;

  accel_result_dma #(.MAX_LEN(4096)) dut (
    .clk(clk), .rst(rst),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wstrb(cfg_wstrb),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_ready(cfg_ready), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fifo_upd();
    fifo_empty = blk_force || gap_blk || fq.size() == 0;
    fifo_rdata = fq.size() != 0 ? fq[0] : 32'd0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (pop_seen) begin
      if (fq.size() != 0) void'(fq.pop_front());
      pops++;
      pop_seen = 0;
    end
    gap_blk = gap_mode && $urandom_range(0, 2) == 0;
    fifo_upd();
    if (!mem_valid) begin
      wait_cnt = 0;
      mem_ready = !rdy_hold && rdy_delay == 0;
    end else begin
      mem_ready = !rdy_hold && wait_cnt >= rdy_delay;
      wait_cnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) prev_v = 1'b0;
    else begin
      if (prev_v && !prev_r && (!mem_valid || mem_addr !== prev_a || mem_wdata !== prev_d)) unstable++;
      prev_v = mem_valid;
      prev_r = mem_ready;
      prev_a = mem_addr;
      prev_d = mem_wdata;
    end
    if (fifo_pop) begin
      pop_seen = 1;
      if (fifo_empty) bad_pop++;
    end
    if (mem_valid && mem_ready) begin
      ga.push_back(mem_addr);
      gd.push_back(mem_wdata);
      gc.push_back(cyc);
      if (mem_wstrb !== 4'hF) bad_strb++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cfg(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d, output logic [31:0] r);
    cfg_addr = a;
    cfg_wstrb = s;
    cfg_wdata = d;
    cfg_sel = 1'b1;
    @(posedge clk); #1;
    check("cfg_ready_rise", 32'(cfg_ready), 32'd1);
    r = cfg_rdata;
    rdy_cyc = cyc;
    @(posedge clk); #1;
    cfg_sel = 1'b0;
    cfg_wstrb = 4'h0;
    check("cfg_ready_fall", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    cfg(a, 4'hF, d, r);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] r);
    cfg(a, 4'h0, 32'd0, r);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (ga.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("beats", 32'(ga.size()), 32'(n));
  endtask

  task automatic run_xfer(input logic [31:0] b, input int n, input int dly, input bit ie, input int hold);
    logic [31:0] w[$];
    logic [31:0] r;
    int p0, sc;
    rdy_delay = dly;
    fq.delete();
    ga.delete(); gd.delete(); gc.delete();
    for (int i = 0; i < n; i++) begin
      w.push_back($urandom);
      fq.push_back(w[i]);
    end
    blk_force = hold > 0;
    fifo_upd();
    p0 = pops;
    wr(BASE_OFS, b);
    wr(LEN_OFS, 32'(n));
    wr(CTRL_OFS, (32'(ie) << CTRL_IRQ_EN) | 32'd1);
    sc = rdy_cyc;
    if (hold > 0) begin
      wait_cycles(hold);
      check("no_pop_empty", 32'(pops - p0), 32'd0);
      check("no_write_empty", 32'(ga.size()), 32'd0);
      blk_force = 0;
      fifo_upd();
    end
    wait_beats(n);
    wait_cycles(3);
    for (int i = 0; i < ga.size() && i < n; i++) begin
      check("addr", ga[i], b + 32'(4 * i));
      check("data", gd[i], w[i]);
      if (dly == 0 && hold == 0 && !gap_mode) check("beat_cycle", 32'(gc[i]), 32'(sc + 2 + 2 * i));
    end
    check("pops", 32'(pops - p0), 32'(n));
    check("irq_done", 32'(irq), 32'(ie));
    rd(STATUS_OFS, r);
    check("status_done", r, (32'(n) << 16) | 32'h2);
    wr(STATUS_OFS, 32'h2);
    check("irq_cleared", 32'(irq), 32'd0);
    rd(STATUS_OFS, r);
    check("status_w1c", r, 32'(n) << 16);
  endtask

  initial begin
    logic [31:0] r;
    int p0, t;
    cfg_sel = 0; cfg_addr = 0; cfg_wstrb = 0; cfg_wdata = 0; mem_ready = 0;
    fifo_upd();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_valid", 32'(mem_valid), 0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_fifo_pop", 32'(fifo_pop), 0);
    check("rst_cfg_ready", 32'(cfg_ready), 0);
    check("rst_cfg_rdata", cfg_rdata, 0);
    check("rst_irq", 32'(irq), 0);
    rst = 0;
    wait_cycles(1);
    rd(STATUS_OFS, r); check("rst_status", r, 0);
    rd(CTRL_OFS, r); check("rst_ctrl", r, 0);
    // register access: clamp and byte strobes
    wr(LEN_OFS, 32'd5000);
    rd(LEN_OFS, r); check("len_clamp", r, 32'd4096);
    wr(BASE_OFS, 32'h11223344);
    cfg(BASE_OFS, 4'b0010, 32'hAABBCCDD, r);
    rd(BASE_OFS, r); check("base_bytes", r, 32'h1122CC44);
    wr(CTRL_OFS, 32'h2);
    rd(CTRL_OFS, r); check("ctrl_irq_en", r, 32'h2);
    // basic transfers with zero-wait memory, with and without irq
    run_xfer(32'h100, 4, 0, 1, 0);
    run_xfer(32'h100, 4, 0, 0, 0);
    // empty FIFO for a while, slow memory
    run_xfer(32'h200, 3, 3, 1, 10);
    // misaligned base and zero length
    fq.delete(); fq.push_back(32'hDEAD0001); fifo_upd();
    ga.delete(); p0 = pops;
    wr(BASE_OFS, 32'h102); wr(LEN_OFS, 32'd2); wr(CTRL_OFS, 32'h1);
    wait_cycles(5);
    rd(STATUS_OFS, r); check("err_status", r, 32'h6);
    check("err_no_write", 32'(ga.size()), 0);
    check("err_no_pop", 32'(pops - p0), 0);
    wr(BASE_OFS, 32'h100); wr(LEN_OFS, 32'd0); wr(CTRL_OFS, 32'h1);
    rd(STATUS_OFS, r); check("len0_status", r, 32'h2);
    check("len0_no_write", 32'(ga.size()), 0);
    check("len0_no_pop", 32'(pops - p0), 0);
    wr(STATUS_OFS, 32'h2);
    // address wrap
    run_xfer(32'hFFFFFFF8, 3, 1, 0, 0);
    // abort while a beat waits for ready; restart attempt while busy
    fq.delete();
    for (int i = 0; i < 8; i++) fq.push_back(32'hC000 + 32'(i));
    fifo_upd();
    ga.delete(); gd.delete(); gc.delete();
    rdy_delay = 0; p0 = pops;
    wr(BASE_OFS, 32'h300); wr(LEN_OFS, 32'd8); wr(CTRL_OFS, 32'h1);
    t = 0;
    while (ga.size() < 2 && t < 200) begin @(negedge clk); t++; end
    rdy_hold = 1;
    wr(CTRL_OFS, 32'h1);
    wr(CTRL_OFS, 32'h4);
    wait_cycles(3);
    check("abort_valid_held", 32'(mem_valid), 1);
    check("abort_beats_before", 32'(ga.size()), 2);
    rdy_hold = 0;
    wait_beats(3);
    wait_cycles(6);
    check("abort_beats", 32'(ga.size()), 3);
    if (ga.size() >= 3) begin
      check("abort_addr", ga[2], 32'h308);
      check("abort_data", gd[2], 32'hC002);
    end
    check("abort_pops", 32'(pops - p0), 3);
    check("abort_fifo_left", 32'(fq.size()), 5);
    rd(STATUS_OFS, r); check("abort_status", r, (32'd3 << 16) | 32'hA);
    wr(STATUS_OFS, 32'h2);
    // randomized transfers
    for (int k = 0; k < 6; k++) begin
      logic [31:0] b;
      gap_mode = $urandom_range(0, 1) == 1;
      b = k == 0 ? 32'hFFFFFFF0 : ($urandom & 32'hFFFFFFFC);
      run_xfer(b, $urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 1) == 1, 0);
    end
    gap_mode = 0;
    // reset in the middle of a stalled beat
    fq.delete();
    for (int i = 0; i < 4; i++) fq.push_back($urandom);
    fifo_upd();
    rdy_hold = 1;
    wr(BASE_OFS, 32'h400); wr(LEN_OFS, 32'd4); wr(CTRL_OFS, 32'h3);
    t = 0;
    while (!mem_valid && t < 50) begin @(posedge clk); #1; t++; end
    check("rst_test_in_write", 32'(mem_valid), 1);
    rst = 1;
    @(posedge clk); #1;
    check("midrst_mem_valid", 32'(mem_valid), 0);
    check("midrst_mem_wstrb", 32'(mem_wstrb), 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_wdata", mem_wdata, 0);
    check("midrst_irq", 32'(irq), 0);
    p0 = pops;
    rst = 0;
    rdy_hold = 0;
    wait_cycles(4);
    rd(STATUS_OFS, r); check("midrst_status", r, 0);
    rd(BASE_OFS, r); check("midrst_base", r, 0);
    rd(LEN_OFS, r); check("midrst_len", r, 0);
    check("midrst_no_pop", 32'(pops - p0), 0);
    check("pop_while_empty", 32'(bad_pop), 0);
    check("unstable_beat", 32'(unstable), 0);
    check("bad_wstrb", 32'(bad_strb), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/accel_result_dma.md
ACCEL_RESULT_DMA -- requirements
Module: accel_result_dma

Interface
REQ-001 SHALL have parameter MAX_LEN, default 4096, meaning the maximum words per transfer; LEN writes above it are clamped.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port fifo_rdata  input  32  head word of the accelerator output FIFO; first-word-fall-through, valid while fifo_empty=0.
REQ-005 SHALL have port fifo_empty  input  1  output FIFO empty flag.
REQ-006 SHALL have port fifo_pop  output  1  one-cycle pop strobe to the output FIFO.
REQ-007 SHALL have ports mem_valid/mem_ready/mem_addr[31:0]/mem_wdata[31:0]/mem_wstrb[3:0]  out/in/out/out/out  write-only bus master, valid/ready handshake.
REQ-008 SHALL have ports cfg_sel  in  1, cfg_addr  in  4 (byte offset), cfg_wstrb  in  4, cfg_wdata  in  32, cfg_rdata  out  32, cfg_ready  out  1  CPU register slave.
REQ-009 SHALL have port irq  output  1  level interrupt = DONE & IRQ_EN.

Function
REQ-010 SHALL decode registers: 0x0 CTRL (bit0 START write-1, bit1 IRQ_EN r/w, bit2 ABORT write-1), 0x4 BASE r/w, 0x8 LEN r/w, 0xC STATUS (bit0 BUSY, bit1 DONE write-1-to-clear, bit2 ERR, bit3 ABORTED, bits[31:16] words written).
REQ-011 SHALL assert cfg_ready exactly one cycle after cfg_sel rises, for one cycle; register write and cfg_rdata capture take effect on that cycle.
REQ-012 SHALL implement FSM IDLE -> FETCH -> WRITE -> FETCH ... -> DONE_ST -> IDLE.
REQ-013 IDLE: on START, SHALL clear DONE/ERR/ABORTED/count, load addr=BASE, remain=LEN, then go to FETCH the next cycle.
REQ-014 START with BASE[1:0]!=0 SHALL set ERR and DONE and stay IDLE with no bus activity.
REQ-015 START with LEN=0 SHALL set DONE within 2 cycles, with no pop and no bus write.
REQ-016 FETCH: when fifo_empty=0, SHALL pulse fifo_pop for one cycle, latch fifo_rdata, and go to WRITE; while empty, SHALL wait indefinitely with no pop.
REQ-017 WRITE: SHALL assert mem_valid with mem_wstrb=4'hF, mem_addr=addr, mem_wdata=latched word, held stable until mem_ready.
REQ-018 On the mem_ready cycle, SHALL drop mem_valid next cycle, set addr+=4 (32-bit wrap, 0xFFFFFFFC -> 0x0), count+=1, remain-=1; go to DONE_ST if remain reaches 0, else FETCH.
REQ-019 Throughput SHALL be one word per 2 cycles with zero-wait mem_ready and non-empty FIFO; the first mem_valid appears 2 cycles after the START cfg_ready cycle.
REQ-020 START while BUSY SHALL be ignored; BASE/LEN writes while BUSY SHALL update the registers but not affect the active transfer.
REQ-021 ABORT in FETCH SHALL go to DONE_ST next cycle without popping; ABORT in WRITE SHALL complete the outstanding beat (mem_valid never dropped before ready) then go to DONE_ST; ABORTED is set in both cases; ABORT in IDLE SHALL be ignored.
REQ-022 DONE_ST SHALL set DONE, clear BUSY, and return to IDLE next cycle; BUSY=1 in all other non-IDLE states.
REQ-023 Simultaneous hardware DONE set and CPU DONE clear SHALL leave DONE=1.
REQ-024 fifo_pop SHALL never assert while fifo_empty=1 or outside FETCH.

Reset
REQ-025 On rst: state=IDLE, mem_valid=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, fifo_pop=0, cfg_ready=0, cfg_rdata=0, irq=0, all registers and count=0.
REQ-026 rst asserted mid-transfer SHALL take effect at the next edge, dropping mem_valid regardless of mem_ready; no further pops.

Structure
REQ-027 Register offsets, CTRL/STATUS bit positions and FSM state encoding SHALL live in shared package accel_dma_pkg.
REQ-028 The block SHALL be a single module with no sub-modules; the register file and FSM share one always block per concern.

Verification
REQ-029 BASE=0x100, LEN=4, FIFO preloaded 0xA0..0xA3, mem_ready tied 1 -> writes 0xA0@0x100 .. 0xA3@0x10C, 4 pops, DONE=1, count=4, irq=1 only if IRQ_EN.
REQ-030 LEN=3, FIFO empty for 10 cycles then 3 words, mem_ready delayed 3 cycles per beat -> no pop while empty, mem_addr/wdata stable across wait, DONE after 3rd ready.
REQ-031 BASE=0x102 START -> ERR=1, DONE=1, zero mem_valid, zero pops; BASE=0x100 LEN=0 -> DONE only.
REQ-032 BASE=0xFFFFFFF8, LEN=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-033 LEN=8, ABORT written while WRITE waits for ready -> beat completes, ABORTED=1, count=beats done, no further pops; second START while BUSY ignored.
REQ-034 rst pulsed during WRITE with mem_ready=0 -> mem_valid=0 next cycle, all STATUS fields 0.
